// File: rtl/text_console_writer.sv
// Character-cell text console writer: turns an ASCII byte stream into video RAM writes and tracks the cursor.
// Optional macro TEXT_CONSOLE_POWERON_CLEAR_EN: clear the whole screen once after reset is released.
module text_console_writer #(
  parameter int COLUMNS = 40,
  parameter int ROWS    = 15,
  parameter int A       = 10,
  parameter int D       = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [7:0]   char_in,
  input  logic         char_valid,
  output logic         char_ready,
  output logic         we,
  output logic [A-1:0] waddr,
  output logic [D-1:0] wdata,
  output logic [5:0]   cursor_col,
  output logic [4:0]   cursor_row,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, WRITE, CLRROW, CLRALL} state_t;

  state_t       state_q, state_nxt;
  logic [5:0]   col_q, col_nxt;
  logic [4:0]   row_q, row_nxt;
  logic [A-1:0] waddr_q, waddr_nxt;
  logic [D-1:0] wdata_q, wdata_nxt;
  logic [15:0]  cnt_q, cnt_nxt;
  logic [15:0]  cnt_last;
  logic         prime_q, prime_nxt;
  logic         pend_q;

  // Full-width cell address, truncated only at the end.
  function automatic logic [A-1:0] cell_addr(input int r, input int c);
    int full;
    full = r * COLUMNS + c;
    return full[A-1:0];
  endfunction

  function automatic logic [4:0] next_row(input logic [4:0] r);
    return (r == 5'(ROWS - 1)) ? 5'd0 : r + 5'd1;
  endfunction

`ifdef TEXT_CONSOLE_POWERON_CLEAR_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pend_q <= 1'b1;
    else          pend_q <= 1'b0;
  end
`else
  assign pend_q = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      prime_q <= 1'b0;
    end else begin
      state_q <= state_nxt;
      col_q   <= col_nxt;
      row_q   <= row_nxt;
      waddr_q <= waddr_nxt;
      wdata_q <= wdata_nxt;
      cnt_q   <= cnt_nxt;
      prime_q <= prime_nxt;
    end
  end

  // A clear entered from IDLE spends one priming cycle (we=0) loading its base address.
  always_comb begin
    state_nxt = state_q;
    col_nxt   = col_q;
    row_nxt   = row_q;
    waddr_nxt = waddr_q;
    wdata_nxt = wdata_q;
    cnt_nxt   = cnt_q;
    prime_nxt = prime_q;
    cnt_last  = (state_q == CLRROW) ? 16'(COLUMNS - 1) : 16'(COLUMNS * ROWS - 1);
    case (state_q)
      IDLE: begin
        if (pend_q) begin
          state_nxt = CLRALL;
          prime_nxt = 1'b1;
        end else if (char_valid) begin
          if (char_in >= 8'h20 && char_in <= 8'h7E) begin
            state_nxt = WRITE;
            waddr_nxt = cell_addr(int'(row_q), int'(col_q));
            wdata_nxt = D'(char_in);
          end else begin
            case (char_in)
              8'h0D: col_nxt = '0;
              8'h08: if (col_q != 6'd0) col_nxt = col_q - 6'd1;
              8'h0A: begin
                row_nxt   = next_row(row_q);
                state_nxt = CLRROW;
                prime_nxt = 1'b1;
              end
              8'h0C: begin
                state_nxt = CLRALL;
                prime_nxt = 1'b1;
              end
              default: ;
            endcase
          end
        end
      end
      WRITE: begin
        if (col_q == 6'(COLUMNS - 1)) begin
          col_nxt   = '0;
          row_nxt   = next_row(row_q);
          state_nxt = CLRROW;
          prime_nxt = 1'b0;
          waddr_nxt = cell_addr(int'(next_row(row_q)), 0);
          wdata_nxt = D'(8'h20);
          cnt_nxt   = '0;
        end else begin
          col_nxt   = col_q + 6'd1;
          state_nxt = IDLE;
        end
      end
      CLRROW, CLRALL: begin
        if (prime_q) begin
          prime_nxt = 1'b0;
          cnt_nxt   = '0;
          wdata_nxt = D'(8'h20);
          waddr_nxt = (state_q == CLRROW) ? cell_addr(int'(row_q), 0) : '0;
        end else if (cnt_q == cnt_last) begin
          state_nxt = IDLE;
          if (state_q == CLRALL) begin
            col_nxt = '0;
            row_nxt = '0;
          end
        end else begin
          cnt_nxt   = cnt_q + 16'd1;
          waddr_nxt = waddr_q + A'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign we         = (state_q == WRITE) ||
                      (((state_q == CLRROW) || (state_q == CLRALL)) && !prime_q);
  assign waddr      = waddr_q;
  assign wdata      = wdata_q;
  assign cursor_col = col_q;
  assign cursor_row = row_q;
  assign busy       = (state_q != IDLE);
  assign char_ready = reset_n && (state_q == IDLE) && !pend_q;

endmodule

// File: tb/tb_text_console_writer.sv
// Directed bench for text_console_writer: vector table plus wrap, row-wrap and reset-abort sequences.
module tb_text_console_writer;

  logic       clk;
  logic       reset_n;
  logic [7:0] char_in;
  logic       char_valid;
  logic       char_ready;
  logic       we;
  logic [9:0] waddr;
  logic [7:0] wdata;
  logic [5:0] cursor_col;
  logic [4:0] cursor_row;
  logic       busy;

  text_console_writer dut (
    .clk(clk), .reset_n(reset_n), .char_in(char_in), .char_valid(char_valid),
    .char_ready(char_ready), .we(we), .waddr(waddr), .wdata(wdata),
    .cursor_col(cursor_col), .cursor_row(cursor_row), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int wa_q[$];
  int wd_q[$];

  always @(negedge clk) begin
    if (reset_n && we) begin
      wa_q.push_back(int'(waddr));
      wd_q.push_back(int'(wdata));
    end
  end

  typedef struct {
    logic [7:0] c;
    int n_wr; int fa; int fd; int la; int ld;
    int col; int row; int bsy;
  } vec_t;

  vec_t vec[13];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic send(input logic [7:0] c, output int bsy);
    int guard;
    guard = 0;
    while (!char_ready && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 2000) chk("ready_timeout", 0, 1);
    wa_q.delete();
    wd_q.delete();
    char_in    = c;
    char_valid = 1'b1;
    @(posedge clk);
    #1 char_valid = 1'b0;
    bsy = 0;
    @(negedge clk);
    while (!char_ready && bsy < 2000) begin
      bsy++;
      @(negedge clk);
    end
  endtask

  task automatic check_vec(input string tag, input vec_t v, input int bsy);
    int contig;
    chk({tag, "_nwr"}, wa_q.size(), v.n_wr);
    if (v.n_wr > 0 && wa_q.size() > 0) begin
      chk({tag, "_first_addr"}, wa_q[0], v.fa);
      chk({tag, "_first_data"}, wd_q[0], v.fd);
      chk({tag, "_last_addr"}, wa_q[wa_q.size()-1], v.la);
      chk({tag, "_last_data"}, wd_q[wd_q.size()-1], v.ld);
      contig = 1;
      for (int i = 1; i < wa_q.size(); i++)
        if (wa_q[i] != wa_q[i-1] + 1) contig = 0;
      chk({tag, "_contiguous"}, contig, 1);
    end
    chk({tag, "_col"}, int'(cursor_col), v.col);
    chk({tag, "_row"}, int'(cursor_row), v.row);
    chk({tag, "_busy_cycles"}, bsy, v.bsy);
  endtask

  initial begin
    int bsy;
    int guard;
    int first;
    vec_t v;
    //         char    n   fa   fd     la   ld     col row busy
    vec[0]  = '{8'h41, 1,   0, 8'h41,   0, 8'h41,  1, 0, 1};
    vec[1]  = '{8'h42, 1,   1, 8'h42,   1, 8'h42,  2, 0, 1};
    vec[2]  = '{8'h08, 0,   0, 0,       0, 0,      1, 0, 0};
    vec[3]  = '{8'h0A, 40, 40, 8'h20,  79, 8'h20,  1, 1, 41};
    vec[4]  = '{8'h63, 1,  41, 8'h63,  41, 8'h63,  2, 1, 1};
    vec[5]  = '{8'h0D, 0,   0, 0,       0, 0,      0, 1, 0};
    vec[6]  = '{8'h07, 0,   0, 0,       0, 0,      0, 1, 0};
    vec[7]  = '{8'h08, 0,   0, 0,       0, 0,      0, 1, 0};
    vec[8]  = '{8'hFF, 0,   0, 0,       0, 0,      0, 1, 0};
    vec[9]  = '{8'h7E, 1,  40, 8'h7E,  40, 8'h7E,  1, 1, 1};
    vec[10] = '{8'h20, 1,  41, 8'h20,  41, 8'h20,  2, 1, 1};
    vec[11] = '{8'h1F, 0,   0, 0,       0, 0,      2, 1, 0};
    vec[12] = '{8'h0C, 600, 0, 8'h20, 599, 8'h20,  0, 0, 601};

    reset_n    = 1'b0;
    char_in    = 8'h00;
    char_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_we", int'(we), 0);
    chk("rst_waddr", int'(waddr), 0);
    chk("rst_wdata", int'(wdata), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(char_ready), 0);
    chk("rst_col", int'(cursor_col), 0);
    chk("rst_row", int'(cursor_row), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      send(vec[i].c, bsy);
      check_vec($sformatf("vec%0d", i), vec[i], bsy);
    end

    // Printable at the last column: write then wrap into a row clear.
    send(8'h0A, bsy);
    send(8'h0A, bsy);
    for (int i = 0; i < 39; i++) send(8'h78, bsy);
    chk("pre_wrap_col", int'(cursor_col), 39);
    chk("pre_wrap_row", int'(cursor_row), 2);
    send(8'h5A, bsy);
    v = '{8'h5A, 41, 119, 8'h5A, 159, 8'h20, 0, 3, 41};
    check_vec("wrap", v, bsy);

    // LF on the last row returns to row 0 and clears it.
    for (int i = 0; i < 11; i++) send(8'h0A, bsy);
    chk("pre_lf_row", int'(cursor_row), 14);
    send(8'h0A, bsy);
    v = '{8'h0A, 40, 0, 8'h20, 39, 8'h20, 0, 0, 41};
    check_vec("lf_last_row", v, bsy);

    // Reset in the middle of a full clear.
    char_in    = 8'h0C;
    char_valid = 1'b1;
    @(posedge clk);
    #1 char_valid = 1'b0;
    guard = 0;
    @(negedge clk);
    while (!(we && waddr == 10'd100) && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    chk("abort_reach_100", int'(guard < 1000), 1);
    reset_n = 1'b0;
    #1;
    chk("abort_we", int'(we), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_ready", int'(char_ready), 0);
    chk("abort_waddr", int'(waddr), 0);
    repeat (2) @(negedge clk);
    wa_q.delete();
    wd_q.delete();
    reset_n = 1'b1;
    repeat (700) @(negedge clk);
`ifdef TEXT_CONSOLE_POWERON_CLEAR_EN
    chk("post_rst_nwr", wa_q.size(), 600);
    first = (wa_q.size() > 0) ? wa_q[0] : -1;
    chk("post_rst_first_addr", first, 0);
`else
    chk("post_rst_nwr", wa_q.size(), 0);
    first = (wa_q.size() > 0) ? wa_q[0] : -1;
    chk("post_rst_first_addr", first, -1);
`endif
    chk("post_rst_ready", int'(char_ready), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/text_console_writer.md
TEXT_CONSOLE_WRITER -- requirements
Module: text_console_writer

Interface
REQ-001 The block SHALL have parameter COLUMNS, default 40: characters per text row.
REQ-002 The block SHALL have parameter ROWS, default 15: text rows on screen.
REQ-003 The block SHALL have parameter A, default 10: video RAM address width.
REQ-004 The block SHALL have parameter D, default 8: video RAM data width.
REQ-005 The block SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-007 The block SHALL have port char_in, input, 8: ASCII character or control code.
REQ-008 The block SHALL have port char_valid, input, 1: char_in is valid.
REQ-009 The block SHALL have port char_ready, output, 1: block accepts char_in this cycle.
REQ-010 The block SHALL have port we, output, 1: video RAM write strobe.
REQ-011 The block SHALL have port waddr, output, A: video RAM write address.
REQ-012 The block SHALL have port wdata, output, D: video RAM write data.
REQ-013 The block SHALL have port cursor_col, output, 6: current column, 0..COLUMNS-1.
REQ-014 The block SHALL have port cursor_row, output, 5: current row, 0..ROWS-1.
REQ-015 The block SHALL have port busy, output, 1: high in any state other than IDLE.

Function
REQ-016 The block SHALL implement states IDLE, WRITE, CLRROW and CLRALL; char_ready SHALL equal 1 only in IDLE.
REQ-017 A character SHALL be accepted on a rising edge where char_valid=1 and char_ready=1; otherwise char_in is ignored.
REQ-018 Accepted printable 0x20..0x7E: go to WRITE; we=1 for exactly the next cycle; waddr=cursor_row*COLUMNS+cursor_col (sampled at acceptance); wdata=char_in zero-extended to D.
REQ-019 After WRITE, cursor_col SHALL increment; at COLUMNS-1 it wraps to 0 and performs the line-advance of REQ-021.
REQ-020 CR (0x0D) SHALL set cursor_col=0 with no write; BS (0x08) SHALL decrement cursor_col if >0, else no change; both return to IDLE in one cycle.
REQ-021 Line-advance (LF 0x0A or column wrap): cursor_row+1, or 0 when at ROWS-1; enter CLRROW, writing 0x20 to the new row's COLUMNS cells, col 0 upward, one per cycle with we=1, then IDLE.
REQ-022 LF SHALL leave cursor_col unchanged; column wrap SHALL set cursor_col=0.
REQ-023 FF (0x0C) SHALL enter CLRALL: write 0x20 to addresses 0..COLUMNS*ROWS-1, one per cycle, ascending; then cursor=(0,0) and IDLE.
REQ-024 All other codes (0x00..0x1F not listed, 0x7F..0xFF) SHALL be accepted and dropped: no write, no cursor change, stay in IDLE.
REQ-025 we SHALL be 0 in IDLE; waddr and wdata SHALL hold their last values when we=0.
REQ-026 Address arithmetic SHALL be computed at full width, then truncated to A bits; waddr SHALL never exceed COLUMNS*ROWS-1.
REQ-027 Throughput: one printable character per 2 cycles; LF costs 1+COLUMNS cycles; FF costs 1+COLUMNS*ROWS cycles.

Reset
REQ-028 On reset_n=0, asynchronously: state=IDLE, cursor=(0,0), we=0, waddr=0, wdata=0, busy=0, char_ready=0 while asserted.
REQ-029 Reset asserted mid-WRITE, CLRROW or CLRALL SHALL abort the operation immediately; no further writes SHALL be issued.

Configuration
REQ-030 With macro TEXT_CONSOLE_POWERON_CLEAR_EN defined, the block SHALL enter CLRALL on the first edge after reset_n deasserts (busy=1, char_ready=0) before first reaching IDLE.
REQ-031 Without TEXT_CONSOLE_POWERON_CLEAR_EN, the block SHALL enter IDLE directly after reset, and RAM contents are left untouched.

Verification
REQ-032 Reset, send 'A' (0x41) -> one we pulse, waddr=0, wdata=0x41; then cursor=(1,0).
REQ-033 From cursor (39,2), send 'Z' -> write at waddr=119; then CLRROW writes 0x20 to 120..159; then cursor=(0,3).
REQ-034 From row 14, send LF -> CLRROW clears 0..39; cursor_row=0; char_ready=0 for 41 cycles.
REQ-035 Send FF -> 600 consecutive we pulses, addresses 0..599, data 0x20; then cursor=(0,0).
REQ-036 Assert reset_n=0 mid-CLRALL at address 100 -> we drops immediately; after release, no writes occur without the macro; with TEXT_CONSOLE_POWERON_CLEAR_EN, a full clear from address 0 occurs.
REQ-037 Send 0x07 then BS at col 0 -> no writes, cursor unchanged, char_ready high again the next cycle.
